// File: rtl/mem_responder.sv
// mem_responder: single-port storage behind a request/acknowledge handshake.
// A request accepted in IDLE waits a fixed number of cycles. The access then
// completes, and the block reports completion with a one-cycle ack.
module mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic [7:0]        txn_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack;
  logic                r_busy;
  logic [7:0]          r_txn_count;
  logic                w_accept;
  logic                w_wait_done;

  // The request is taken only in IDLE. The access completes on the last WAIT edge.
  assign w_accept    = (r_state == S_IDLE) && valid;
  assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == '0);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  // NOTE: defaulting w_next first keeps this block purely combinational (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (valid) w_next = S_WAIT;
      S_WAIT:  if (r_wait_cnt == '0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the request and run the wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_rw       <= rw;
      r_addr     <= addr;
      r_wdata    <= wdata;
      r_wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
    end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  // Storage: a write commits on the edge that leaves WAIT.
  // NOTE: storage is reset explicitly because reset must read back as zero;
  // this also prevents the array from mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wait_done && !r_rw) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // Read data: updated only on the completion of a read. It holds otherwise.
  always_ff @(posedge clk) begin
    if (rst)                     r_rdata <= '0;
    else if (w_wait_done && r_rw) r_rdata <= r_mem[r_addr];
  end

  // ack and busy are registered from the next state so they match the state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ack  <= (w_next == S_RESP);
      r_busy <= (w_next != S_IDLE);
    end
  end

  // Completed-transaction counter. It counts on RESP exit and wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst)                    r_txn_count <= '0;
    else if (r_state == S_RESP) r_txn_count <= r_txn_count + 8'd1;
  end

  assign rdata     = r_rdata;
  assign ack       = r_ack;
  assign busy      = r_busy;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Directed scenarios are followed by randomized
// traffic. All traffic is checked against a transaction-level model that tracks
// storage contents, last read data and the completion count.
module tb_mem_responder;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int W  = 2;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          busy;
  logic [7:0]    txn_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] m_mem [1 << AW];
  logic [DW-1:0] m_rdata;
  logic [7:0]    m_cnt;

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .rw        (rw),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .busy      (busy),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    m_rdata = '0;
    m_cnt   = '0;
  endtask

  task automatic check_outputs(input string where, input logic e_busy, input logic e_ack);
    check({where, "/busy"}, 32'(busy), 32'(e_busy));
    check({where, "/ack"}, 32'(ack), 32'(e_ack));
    check({where, "/rdata"}, 32'(rdata), 32'(m_rdata));
    check({where, "/txn_count"}, 32'(txn_count), 32'(m_cnt));
  endtask

  // Hold reset for n cycles and check the cleared outputs after each reset edge.
  task automatic apply_reset(input int n);
    rst = 1'b1; valid = 1'b0;
    model_reset();
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs("reset", 1'b0, 1'b0);
    end
    rst = 1'b0;
  endtask

  // Issue one request from IDLE at a negedge and follow it until the block is back in IDLE.
  // mode 0: inputs quiet during WAIT; 1: random junk; 2: valid=1, addr=7, wdata=0xFF.
  task automatic do_txn(input logic t_rw, input logic [AW-1:0] t_addr,
                        input logic [DW-1:0] t_data, input int mode);
    valid = 1'b1; rw = t_rw; addr = t_addr; wdata = t_data;
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == W) begin
        if (t_rw) m_rdata = m_mem[t_addr];
        else      m_mem[t_addr] = t_data;
      end
      if (k == W + 1) m_cnt = m_cnt + 8'd1;
      check_outputs("txn", (k <= W), (k == W));
      if (k < W && mode == 1) begin
        valid = 1'($urandom); rw = 1'($urandom);
        addr = AW'($urandom); wdata = DW'($urandom);
      end else if (k < W && mode == 2) begin
        valid = 1'b1; addr = 4'd7; wdata = 8'hFF;
      end else begin
        valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic prev_ack;
    rst = 1'b1; valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0;

    // Reset, then a quiet idle period.
    apply_reset(2);
    repeat (5) begin
      @(negedge clk);
      check_outputs("idle", 1'b0, 1'b0);
    end

    // Write 0xA5 to address 3, then read it back.
    do_txn(1'b0, 4'd3, 8'hA5, 0);
    do_txn(1'b1, 4'd3, 8'h00, 0);
    check("wr_rd/rdata", 32'(rdata), 32'h0000_00A5);
    check("wr_rd/txn_count", 32'(txn_count), 32'd2);

    // Inputs that change during WAIT must not disturb the accepted request.
    do_txn(1'b0, 4'd5, 8'h3C, 2);
    do_txn(1'b1, 4'd5, 8'h00, 0);
    check("midchg/mem5", 32'(rdata), 32'h0000_003C);
    do_txn(1'b1, 4'd7, 8'h00, 0);
    check("midchg/mem7", 32'(rdata), 32'h0000_0000);

    // Hold valid high: a read of address 0 completes every 1+W+1 cycles.
    valid = 1'b1; rw = 1'b1; addr = '0;
    prev_ack = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i % (W + 2) == W + 1) m_rdata = m_mem[0];
      if (i % (W + 2) == 0)     m_cnt = m_cnt + 8'd1;
      check_outputs("held", (i % (W + 2) != 0), (i % (W + 2) == W + 1));
      check("held/ack_consecutive", 32'(prev_ack & ack), 32'd0);
      prev_ack = ack;
    end
    valid = 1'b0;

    // Reset and valid in the same cycle: the request is discarded.
    rst = 1'b1; valid = 1'b1; rw = 1'b0; addr = 4'd2; wdata = 8'h77;
    model_reset();
    @(negedge clk);
    check_outputs("rst_vs_valid", 1'b0, 1'b0);
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    check_outputs("rst_vs_valid_after", 1'b0, 1'b0);
    do_txn(1'b1, 4'd2, 8'h00, 0);

    // Reset in the first WAIT cycle aborts the write.
    valid = 1'b1; rw = 1'b0; addr = 4'd1; wdata = 8'h11;
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("rst_in_wait", 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_outputs("rst_in_wait_after", 1'b0, 1'b0);
    end
    do_txn(1'b1, 4'd1, 8'h00, 0);
    check("rst_in_wait/mem1", 32'(rdata), 32'd0);

    // Reset during RESP suppresses the count increment and clears the committed write.
    valid = 1'b1; rw = 1'b0; addr = 4'd9; wdata = 8'h5A;
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      valid = 1'b0;
      check("rst_in_resp/ack", 32'(ack), 32'(k == W));
    end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_outputs("rst_in_resp", 1'b0, 1'b0);
    rst = 1'b0;
    do_txn(1'b1, 4'd9, 8'h00, 0);

    // Random traffic up to and across the counter wrap.
    apply_reset(1);
    for (int n = 0; n < 256; n++)
      do_txn(1'($urandom), AW'($urandom), DW'($urandom), 1);
    check("wrap/txn_count_256", 32'(txn_count), 32'd0);
    do_txn(1'($urandom), AW'($urandom), DW'($urandom), 1);
    check("wrap/txn_count_257", 32'(txn_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DATA_W, 8, width of the data bus and of each storage word.
REQ-002 Parameter: ADDR_W, 4, address width; storage depth is 2**ADDR_W words.
REQ-003 Parameter: WAIT_CYCLES, 2, access wait states; legal range 1..15.
REQ-004 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: valid  input  1  request strobe from initiator FSM.
REQ-007 Port: rw  input  1  request type; 1 = read, 0 = write.
REQ-008 Port: addr  input  ADDR_W  request address.
REQ-009 Port: wdata  input  DATA_W  write data.
REQ-010 Port: rdata  output  DATA_W  read data of the most recent completed read.
REQ-011 Port: ack  output  1  one-cycle completion pulse.
REQ-012 Port: busy  output  1  high while a request is in progress.
REQ-013 Port: txn_count  output  8  count of completed transactions.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 In IDLE, valid=1 at a rising edge SHALL capture rw, addr and wdata into internal registers and move to WAIT.
REQ-016 In IDLE with valid=0, the block SHALL stay in IDLE.
REQ-017 Entering WAIT SHALL load the wait counter; the FSM SHALL stay in WAIT for exactly WAIT_CYCLES cycles and then move to RESP.
REQ-018 The edge leaving WAIT SHALL commit a write (mem[addr_q] <= wdata_q) or load a read (rdata <= mem[addr_q]).
REQ-019 RESP SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 ack SHALL be a registered output, 1 only in RESP.
REQ-021 busy SHALL be a registered output, 1 in WAIT and RESP and 0 in IDLE.
REQ-022 Latency: valid sampled at edge N SHALL produce ack=1 in the cycle between edges N+WAIT_CYCLES and N+WAIT_CYCLES+1.
REQ-023 valid, rw, addr and wdata SHALL be ignored in WAIT and RESP.
REQ-024 A valid still held high through RESP SHALL be accepted as a new request in the following IDLE cycle; the initiator deasserts valid on ack.
REQ-025 rdata SHALL change only on read completion or reset and SHALL hold its value across writes and idle cycles.
REQ-026 A read of an address written by an earlier completed write SHALL return that write's data, including back-to-back write then read.
REQ-027 txn_count SHALL increment by 1 on the edge leaving RESP and SHALL wrap from 255 to 0.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE and clear ack=0, busy=0, rdata=0, txn_count=0, the wait counter and all storage words to 0.
REQ-029 rst SHALL take priority over valid in the same cycle; that request SHALL be discarded.
REQ-030 rst during WAIT SHALL abort the request with no memory write, no rdata update and no ack pulse.
REQ-031 rst during RESP SHALL suppress the txn_count increment; a write already committed is cleared by the storage reset.

Verification
REQ-032 Reset then idle: rst high 2 cycles, valid=0 for 5 cycles -> ack=0, busy=0, rdata=0x00, txn_count=0 throughout.
REQ-033 Write then read (WAIT_CYCLES=2): write addr=3, wdata=0xA5 at edge N -> busy=1 from N, ack=1 only in cycle N+2..N+3; then read addr=3 -> rdata=0xA5 with ack; txn_count=2.
REQ-034 Held valid: valid=1, rw=1, addr=0 held for 12 cycles -> ack pulses every 4 cycles (IDLE+2 WAIT+RESP), never two consecutive cycles high.
REQ-035 Input changes mid-request: write addr=5, wdata=0x3C accepted, then addr=7 and wdata=0xFF driven during WAIT -> mem[5]=0x3C, mem[7] unchanged (0x00 on readback).
REQ-036 Reset mid-operation: write addr=1, wdata=0x11, rst asserted in the first WAIT cycle -> no ack, busy=0 after the reset edge, read of addr=1 returns 0x00.
REQ-037 Counter wrap: 256 completed transactions after reset -> txn_count returns to 0x00 on the 256th RESP exit; one more transaction -> 0x01.
